// File: rtl/fifo_srl_feeder_if.sv
// Stream and FIFO-write bundle for fifo_srl_feeder.
// The slave modport is the feeder's view; master is the upstream/FIFO side.
interface fifo_srl_feeder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH:0]   fifo_di;
  logic             fifo_wren;
  logic             fifo_full;
  logic             fifo_afull;

  modport slave (
    input  s_data, s_last, s_valid, fifo_full, fifo_afull,
    output s_ready, fifo_di, fifo_wren
  );

  modport master (
    output s_data, s_last, s_valid, fifo_full, fifo_afull,
    input  s_ready, fifo_di, fifo_wren
  );
endinterface

// File: rtl/fifo_srl_feeder.sv
// Fixed-latency write feeder for the SRL FWFT FIFO, with flush/drain control.
// Optional drop-on-full overflow check is built when FIFO_FEEDER_OVF_CHK_EN is defined.
module fifo_srl_feeder #(
  parameter int WIDTH = 16,
  parameter int LAT   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_srl_feeder_if.slave   bus,
  input  logic               flush,
  output logic               flush_done,
  output logic               busy,
  output logic [15:0]        wr_count,
  output logic               ovf
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_flush_done;
  logic [LAT-1:0]   r_vld;
  logic [LAT-1:0]   r_last;
  logic [WIDTH-1:0] r_data [LAT];
  logic [15:0]      r_wr_count;

  logic w_accept;
  logic w_last_vld;
  logic w_wren;

  assign bus.s_ready = (r_state == ST_RUN) & ~bus.fifo_afull & ~flush;
  assign w_accept    = bus.s_valid & bus.s_ready;

  // Free-running shift pipeline: no stall, so the afull margin must cover LAT words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_last <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0]  <= w_accept;
      r_last[0] <= bus.s_last;
      r_data[0] <= bus.s_data;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_last[i] <= r_last[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign w_last_vld  = r_vld[LAT-1];
  assign bus.fifo_di = {r_last[LAT-1], r_data[LAT-1]};
  assign busy        = |r_vld;

`ifdef FIFO_FEEDER_OVF_CHK_EN
  logic w_drop;
  logic r_ovf;

  assign w_drop = w_last_vld & bus.fifo_full;
  assign w_wren = w_last_vld & ~bus.fifo_full;
  assign ovf    = r_ovf | w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end
`else
  logic w_unused_full;

  assign w_unused_full = bus.fifo_full;
  assign w_wren        = w_last_vld;
  assign ovf           = 1'b0;
`endif

  assign bus.fifo_wren = w_wren;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_count <= '0;
    end else if (w_wren) begin
      r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign wr_count = r_wr_count;

  // An empty pipeline at flush time skips DRAIN and reports done on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_flush_done <= 1'b0;
          if (flush) begin
            if (busy) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state      <= ST_DONE;
              r_flush_done <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!busy) begin
            r_state      <= ST_DONE;
            r_flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state      <= ST_RUN;
          r_flush_done <= 1'b0;
        end
        default: begin
          r_state      <= ST_RUN;
          r_flush_done <= 1'b0;
        end
      endcase
    end
  end

  assign flush_done = r_flush_done;

endmodule

// File: tb/tb_fifo_srl_feeder.sv
// Scoreboard bench for fifo_srl_feeder: the driver queues expected FIFO writes with
// their due cycle, and an independent monitor checks every cycle's write port.
module tb_fifo_srl_feeder;
  localparam int WIDTH = 16;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        flush_done;
  logic        busy;
  logic        ovf;
  logic [15:0] wr_count;

  always #5 clk = ~clk;

  fifo_srl_feeder_if #(.WIDTH(WIDTH)) bus ();

  fifo_srl_feeder #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy),
    .wr_count   (wr_count),
    .ovf        (ovf)
  );

  typedef struct {
    logic [WIDTH:0] di;
    int             due;
    bit             drop;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   quiet = 1'b0;

`ifdef FIFO_FEEDER_OVF_CHK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle the write port must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL wren_missed: got no write, required di=0x%0h due cycle %0d", e.di, e.due);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("wren", 32'(bus.fifo_wren), 32'(!e.drop));
        if (!e.drop) check("fifo_di", 32'(bus.fifo_di), 32'(e.di));
        if (!quiet) $display("write cycle=%0d wren=%0b di=0x%05h", cyc, bus.fifo_wren, bus.fifo_di);
      end else begin
        check("idle_wren", 32'(bus.fifo_wren), 32'd0);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One cycle of stimulus; checks s_ready/flush_done and queues an accepted word.
  task automatic step(input logic v, input logic [15:0] d, input logic l,
                      input logic exp_rdy, input logic exp_fd);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_last  = l;
    @(negedge clk);
    check("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
    check("flush_done", 32'(flush_done), 32'(exp_fd));
    if (v && exp_rdy) q.push_back('{di: {l, d}, due: cyc + LAT, drop: 1'b0});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.s_last     = 1'b0;
    bus.fifo_full  = 1'b0;
    bus.fifo_afull = 1'b0;
    flush          = 1'b0;
    rst_n          = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_wren", 32'(bus.fifo_wren), 32'd0);
    check("rst_di", 32'(bus.fifo_di), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Four back-to-back words
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b1, 1'b0);
    idle(LAT + 2);
    check("t1_wr_count", 32'(wr_count), 32'd4);

    // afull backpressure with one word in flight
    step(1'b1, 16'h0010, 1'b1, 1'b1, 1'b0);
    bus.fifo_afull = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    bus.fifo_afull = 1'b0;
    step(1'b1, 16'h0012, 1'b0, 1'b1, 1'b0);
    idle(LAT + 2);
    check("t2_wr_count", 32'(wr_count), 32'd6);

    // Flush with two words in flight
    step(1'b1, 16'h0021, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h0022, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    step(1'b1, 16'h0023, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
    check("t3_busy_drain", 32'(busy), 32'd1);
    step(1'b1, 16'h0024, 1'b0, 1'b0, 1'b0);
    check("t3_busy_fall", 32'(busy), 32'd0);
    step(1'b1, 16'h0025, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("t3_wr_count", 32'(wr_count), 32'd8);

    // Flush with an empty pipeline
    flush = 1'b1;
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
    step(1'b1, 16'h0026, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Reset with two words in flight
    step(1'b1, 16'h0031, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h0032, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    q.delete();
    bus.s_valid = 1'b0;
    #1;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_wr_count", 32'(wr_count), 32'd0);
    bus.fifo_afull = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    bus.fifo_afull = 1'b0;
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("t4_wr_count_after", 32'(wr_count), 32'd0);

    // wr_count wrap
    quiet = 1'b1;
    for (int i = 0; i < 65534; i++) step(1'b1, i[15:0], i[0], 1'b1, 1'b0);
    idle(LAT + 1);
    check("t5_wr_count_fffe", 32'(wr_count), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hA000 + 16'(i), 1'b1, 1'b1, 1'b0);
    idle(LAT + 1);
    check("t5_wr_count_wrap", 32'(wr_count), 32'h0000_0001);
    quiet = 1'b0;

    // fifo_full while a word sits in the last stage
    step(1'b1, 16'h0041, 1'b1, 1'b1, 1'b0);
    q[$].drop = OVF_EN;
    for (int i = 0; i < LAT - 1; i++) step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    bus.fifo_full = 1'b1;
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    bus.fifo_full = 1'b0;
    check("t6_ovf", 32'(ovf), 32'(OVF_EN));
    check("t6_wr_count", 32'(wr_count), OVF_EN ? 32'd1 : 32'd2);
    step(1'b1, 16'h0042, 1'b0, 1'b1, 1'b0);
    idle(LAT + 1);
    check("t6_ovf_sticky", 32'(ovf), 32'(OVF_EN));
    check("t6_wr_count_after", 32'(wr_count), OVF_EN ? 32'd2 : 32'd3);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
